// File: rtl/shift_counter_pkg.sv
// Shared mode constants and per-mode sequence configuration for the shift counter family.
package shift_counter_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;

    typedef struct packed {
        logic [31:0] rst_val;
        logic [31:0] period;
    } seq_cfg_t;

    // Johnson restarts from all-zeros and cycles 2*WIDTH states; ring restarts one-hot at bit0.
    function automatic seq_cfg_t seq_cfg(input int mode, input int width);
        seq_cfg_t cfg;
        if (mode == MODE_RING) begin
            cfg.rst_val = 32'd1;
            cfg.period  = 32'(width);
        end else begin
            cfg.rst_val = 32'd0;
            cfg.period  = 32'(2 * width);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational legality check and sequence-index decode of the counter state.
module shift_counter_decode
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON
) (
    input  logic [WIDTH-1:0]           i_q,
    output logic                       o_legal,
    output logic [$clog2(2*WIDTH)-1:0] o_phase
);

    localparam int               PW  = $clog2(2*WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] w_inv;
    logic             w_low_run;
    logic             w_high_run;
    int               w_ones;
    int               w_idx;

    always_comb begin
        w_ones = 0;
        w_idx  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_q[i]) begin
                w_ones = w_ones + 1;
                w_idx  = i;
            end
        end
    end

    // Johnson states are exactly a run of ones anchored at the LSB (0..01..1)
    // or a run of ones anchored at the MSB (1..10..0).
    assign w_inv      = ~i_q;
    assign w_low_run  = ((i_q & (i_q + ONE)) == '0);
    assign w_high_run = ((w_inv & (w_inv + ONE)) == '0);

    always_comb begin
        o_legal = 1'b0;
        o_phase = '0;
        if (MODE == MODE_RING) begin
            o_legal = (w_ones == 1);
            if (w_ones == 1) begin
                o_phase = w_idx[PW-1:0];
            end
        end else begin
            o_legal = w_low_run | w_high_run;
            if (w_low_run) begin
                o_phase = w_ones[PW-1:0];
            end else if (w_high_run) begin
                o_phase = PW'(2 * WIDTH - w_ones);
            end
        end
    end

endmodule

// File: rtl/shift_counter_param.sv
// Parameterised Johnson / ring shift counter with parallel load and illegal-state recovery.
module shift_counter_param
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       dir,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_val,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(2*WIDTH)-1:0] phase,
    output logic                       tc,
    output logic                       err
);

    localparam int               PW      = $clog2(2*WIDTH);
    localparam seq_cfg_t         CFG     = seq_cfg(MODE, WIDTH);
    localparam logic [WIDTH-1:0] RST_VAL = CFG.rst_val[WIDTH-1:0];
    localparam logic [PW-1:0]    PH_LAST = PW'(CFG.period - 32'd1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("shift_counter_param: WIDTH must be within 2..32");
    end
    if (MODE != MODE_JOHNSON && MODE != MODE_RING) begin : g_bad_mode
        $error("shift_counter_param: MODE must be 0 (Johnson) or 1 (ring)");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_err;
    logic [WIDTH-1:0] w_next;
    logic             w_corr;
    logic             w_legal;
    logic [PW-1:0]    w_phase;

    shift_counter_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_decode (
        .i_q     (r_q),
        .o_legal (w_legal),
        .o_phase (w_phase)
    );

    // Loads are taken verbatim; an illegal state is only repaired on an enabled edge.
    always_comb begin
        w_next = r_q;
        w_corr = 1'b0;
        if (load) begin
            w_next = load_val;
        end else if (en) begin
            if (!w_legal) begin
                w_next = RST_VAL;
                w_corr = 1'b1;
            end else if (MODE == MODE_RING) begin
                w_next = dir ? {r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            end else begin
                w_next = dir ? {~r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= RST_VAL;
            r_err <= 1'b0;
        end else begin
            r_q   <= w_next;
            r_err <= w_corr;
        end
    end

    assign q     = r_q;
    assign phase = w_phase;
    assign err   = r_err;
    assign tc    = en & ~load & w_legal & (dir ? (w_phase == '0) : (w_phase == PH_LAST));

endmodule

// File: tb/tb_shift_counter_param.sv
// Randomised and directed bench for shift_counter_param against a sequence-table reference model.
module tb_shift_counter_param;

    localparam int N = 3;
    localparam int W_T    [N] = '{4, 4, 8};
    localparam int MODE_T [N] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        en   [N];
    logic        dir  [N];
    logic        load [N];
    logic [31:0] lv   [N];

    logic [3:0] q0, q1;
    logic [7:0] q2;
    logic [2:0] ph0, ph1;
    logic [3:0] ph2;
    logic       tc0, tc1, tc2, err0, err1, err2;

    logic [31:0] qv  [N];
    logic [31:0] phv [N];
    logic        tcv [N];
    logic        errv[N];

    logic [31:0] mq   [N];
    logic        merr [N];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    shift_counter_param #(.WIDTH(4), .MODE(0)) dut_j4 (
        .clk(clk), .rst(rst), .en(en[0]), .dir(dir[0]), .load(load[0]),
        .load_val(lv[0][3:0]), .q(q0), .phase(ph0), .tc(tc0), .err(err0));
    shift_counter_param #(.WIDTH(4), .MODE(1)) dut_r4 (
        .clk(clk), .rst(rst), .en(en[1]), .dir(dir[1]), .load(load[1]),
        .load_val(lv[1][3:0]), .q(q1), .phase(ph1), .tc(tc1), .err(err1));
    shift_counter_param #(.WIDTH(8), .MODE(0)) dut_j8 (
        .clk(clk), .rst(rst), .en(en[2]), .dir(dir[2]), .load(load[2]),
        .load_val(lv[2][7:0]), .q(q2), .phase(ph2), .tc(tc2), .err(err2));

    assign qv[0]  = {28'd0, q0};
    assign qv[1]  = {28'd0, q1};
    assign qv[2]  = {24'd0, q2};
    assign phv[0] = {29'd0, ph0};
    assign phv[1] = {29'd0, ph1};
    assign phv[2] = {28'd0, ph2};
    assign tcv[0] = tc0;
    assign tcv[1] = tc1;
    assign tcv[2] = tc2;
    assign errv[0] = err0;
    assign errv[1] = err1;
    assign errv[2] = err2;

    // ---------------- reference model: sequence listed by index ----------------
    function automatic int period_of(input int d);
        return (MODE_T[d] == 1) ? W_T[d] : 2 * W_T[d];
    endfunction

    function automatic logic [31:0] mask_of(input int d);
        logic [63:0] m;
        m = (64'd1 << W_T[d]) - 64'd1;
        return m[31:0];
    endfunction

    // State at sequence index p, counting up from the restart value.
    function automatic logic [31:0] state_at(input int d, input int p);
        logic [63:0] v;
        if (MODE_T[d] == 1)      v = 64'd1 << p;
        else if (p <= W_T[d])    v = (64'd1 << p) - 64'd1;
        else                     v = {32'd0, mask_of(d)} & ~((64'd1 << (p - W_T[d])) - 64'd1);
        return v[31:0];
    endfunction

    // Index of v in the sequence, -1 when v never occurs in it.
    function automatic int phase_of(input int d, input logic [31:0] v);
        for (int p = 0; p < period_of(d); p++)
            if (state_at(d, p) == v) return p;
        return -1;
    endfunction

    function automatic logic [31:0] exp_phase(input int d);
        int p;
        p = phase_of(d, mq[d]);
        return (p < 0) ? 32'd0 : 32'(p);
    endfunction

    function automatic logic exp_tc(input int d);
        int p;
        p = phase_of(d, mq[d]);
        if (!en[d] || load[d] || p < 0) return 1'b0;
        return dir[d] ? (p == 0) : (p == period_of(d) - 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            mq[d]   = state_at(d, 0);
            merr[d] = 1'b0;
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < N; d++) begin
            en[d] = 1'b0; dir[d] = 1'b0; load[d] = 1'b0; lv[d] = 32'd0;
        end
    endtask

    // One clock edge for every DUT; model advances from the inputs held across the edge.
    task automatic tick();
        logic [31:0] nq [N];
        logic        ne [N];
        int          p, per;
        for (int d = 0; d < N; d++) begin
            nq[d] = mq[d];
            ne[d] = 1'b0;
            per   = period_of(d);
            if (load[d]) begin
                nq[d] = lv[d] & mask_of(d);
            end else if (en[d]) begin
                p = phase_of(d, mq[d]);
                if (p < 0) begin
                    nq[d] = state_at(d, 0);
                    ne[d] = 1'b1;
                end else begin
                    nq[d] = state_at(d, dir[d] ? (p + per - 1) % per : (p + 1) % per);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            mq[d]   = nq[d];
            merr[d] = ne[d];
        end
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        for (int d = 0; d < N; d++) begin
            en[d] = 1'b1; load[d] = 1'b1; lv[d] = 32'h5A;
        end
        rst = 1'b1;
        #2;
        for (int d = 0; d < N; d++) begin
            n_total++;
            if (qv[d] !== state_at(d, 0)) $display("FAIL reset_q d%0d: got %0h expected %0h", d, qv[d], state_at(d, 0));
            else n_pass++;
            n_total++;
            if (errv[d] !== 1'b0) $display("FAIL reset_err d%0d: got %0b expected 0", d, errv[d]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            n_total++;
            if (qv[d] !== state_at(d, 0)) $display("FAIL reset_hold_q d%0d: got %0h expected %0h", d, qv[d], state_at(d, 0));
            else n_pass++;
        end
        rst = 1'b0;
        idle_all();
        model_reset();
    endtask

    task automatic test_johnson_up();
        logic [31:0] exp_q [8];
        exp_q = '{32'h1, 32'h3, 32'h7, 32'hF, 32'hE, 32'hC, 32'h8, 32'h0};
        do_reset();
        en[0] = 1'b1; dir[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_total++;
            if (phv[0] !== 32'(i)) $display("FAIL jup_phase step%0d: got %0d expected %0d", i, phv[0], i);
            else n_pass++;
            n_total++;
            if (tcv[0] !== (i == 7)) $display("FAIL jup_tc step%0d: got %0b expected %0b", i, tcv[0], (i == 7));
            else n_pass++;
            tick();
            n_total++;
            if (qv[0] !== exp_q[i] || qv[0] !== mq[0]) $display("FAIL jup_q step%0d: got %0h expected %0h", i, qv[0], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_johnson_down();
        logic [31:0] exp_q [8];
        exp_q = '{32'h8, 32'hC, 32'hE, 32'hF, 32'h7, 32'h3, 32'h1, 32'h0};
        do_reset();
        en[0] = 1'b1; dir[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_total++;
            if (tcv[0] !== (i == 0)) $display("FAIL jdn_tc step%0d: got %0b expected %0b", i, tcv[0], (i == 0));
            else n_pass++;
            tick();
            n_total++;
            if (qv[0] !== exp_q[i] || qv[0] !== mq[0]) $display("FAIL jdn_q step%0d: got %0h expected %0h", i, qv[0], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal_load();
        do_reset();
        load[0] = 1'b1; lv[0] = 32'h5;
        tick();
        load[0] = 1'b0; en[0] = 1'b1;
        #1;
        n_total++;
        if (qv[0] !== 32'h5 || phv[0] !== 32'd0 || tcv[0] !== 1'b0)
            $display("FAIL jill_load: got q=%0h ph=%0d tc=%0b expected q=5 ph=0 tc=0", qv[0], phv[0], tcv[0]);
        else n_pass++;
        tick();
        n_total++;
        if (qv[0] !== 32'h0 || errv[0] !== 1'b1) $display("FAIL jill_fix: got q=%0h err=%0b expected q=0 err=1", qv[0], errv[0]);
        else n_pass++;
        tick();
        n_total++;
        if (errv[0] !== 1'b0 || qv[0] !== mq[0]) $display("FAIL jill_pulse: got q=%0h err=%0b expected q=%0h err=0", qv[0], errv[0], mq[0]);
        else n_pass++;
    endtask

    task automatic test_ring();
        logic [31:0] exp_q [4];
        exp_q = '{32'h2, 32'h4, 32'h8, 32'h1};
        do_reset();
        en[1] = 1'b1; dir[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (tcv[1] !== (i == 3) || phv[1] !== 32'(i))
                $display("FAIL ring_tc step%0d: got tc=%0b ph=%0d expected tc=%0b ph=%0d", i, tcv[1], phv[1], (i == 3), i);
            else n_pass++;
            tick();
            n_total++;
            if (qv[1] !== exp_q[i] || qv[1] !== mq[1]) $display("FAIL ring_q step%0d: got %0h expected %0h", i, qv[1], exp_q[i]);
            else n_pass++;
        end
        load[1] = 1'b1; lv[1] = 32'h6;
        tick();
        load[1] = 1'b0;
        n_total++;
        if (qv[1] !== 32'h6 || errv[1] !== 1'b0) $display("FAIL ring_load: got q=%0h err=%0b expected q=6 err=0", qv[1], errv[1]);
        else n_pass++;
        tick();
        n_total++;
        if (qv[1] !== 32'h1 || errv[1] !== 1'b1) $display("FAIL ring_fix: got q=%0h err=%0b expected q=1 err=1", qv[1], errv[1]);
        else n_pass++;
    endtask

    task automatic test_hold_async();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (qv[0] !== 32'h0) $display("FAIL hold_q cyc%0d: got %0h expected 0", i, qv[0]);
            else n_pass++;
        end
        load[0] = 1'b1; lv[0] = 32'h3;
        tick();
        load[0] = 1'b0; en[0] = 1'b1;
        tick();
        n_total++;
        if (qv[0] !== 32'h7) $display("FAIL hold_load_step: got %0h expected 7", qv[0]);
        else n_pass++;
        load[0] = 1'b1; lv[0] = 32'hF;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (qv[0] !== 32'h0 || errv[0] !== 1'b0) $display("FAIL async_rst_q: got q=%0h err=%0b expected q=0 err=0", qv[0], errv[0]);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_all();
        model_reset();
        // err raised by a correction must also drop at once on reset
        load[0] = 1'b1; lv[0] = 32'h9;
        tick();
        load[0] = 1'b0; en[0] = 1'b1;
        tick();
        n_total++;
        if (errv[0] !== 1'b1) $display("FAIL async_err_pre: got %0b expected 1", errv[0]);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if (errv[0] !== 1'b0) $display("FAIL async_err: got %0b expected 0", errv[0]);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_all();
        model_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        load[0] = 1'b1; lv[0] = 32'h8;
        tick();
        en[0] = 1'b1; lv[0] = 32'h3;
        #1;
        n_total++;
        if (tcv[0] !== 1'b0) $display("FAIL b2b_tc: got %0b expected 0", tcv[0]);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            lv[0] = 32'($urandom_range(0, 15));
            tick();
            n_total++;
            if (qv[0] !== mq[0] || errv[0] !== 1'b0) $display("FAIL b2b_q cyc%0d: got %0h expected %0h", i, qv[0], mq[0]);
            else n_pass++;
        end
    endtask

    task automatic test_dir_change();
        do_reset();
        en[0] = 1'b1; en[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            dir[0] = 1'($urandom_range(0, 1));
            dir[1] = 1'($urandom_range(0, 1));
            tick();
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (qv[d] !== mq[d]) $display("FAIL dirchg_q d%0d cyc%0d: got %0h expected %0h", d, i, qv[d], mq[d]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_w8();
        int tc_count;
        tc_count = 0;
        do_reset();
        en[2] = 1'b1; dir[2] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (tcv[2] === 1'b1) tc_count++;
            n_total++;
            if (phv[2] !== 32'(i)) $display("FAIL w8_phase step%0d: got %0d expected %0d", i, phv[2], i);
            else n_pass++;
            tick();
        end
        n_total++;
        if (qv[2] !== 32'h0 || tc_count != 1) $display("FAIL w8_wrap: got q=%0h tc_count=%0d expected q=0 tc_count=1", qv[2], tc_count);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < N; d++) begin
                en[d]   = ($urandom_range(0, 3) != 0);
                dir[d]  = 1'($urandom_range(0, 1));
                load[d] = ($urandom_range(0, 9) == 0);
                lv[d]   = $urandom() & mask_of(d);
            end
            #1;
            for (int d = 0; d < N; d++) begin
                n_total++;
                if (phv[d] !== exp_phase(d) || tcv[d] !== exp_tc(d))
                    $display("FAIL rnd_comb d%0d cyc%0d: got ph=%0d tc=%0b expected ph=%0d tc=%0b",
                             d, i, phv[d], tcv[d], exp_phase(d), exp_tc(d));
                else n_pass++;
            end
            tick();
            for (int d = 0; d < N; d++) begin
                n_total++;
                if (qv[d] !== mq[d] || errv[d] !== merr[d])
                    $display("FAIL rnd_reg d%0d cyc%0d: got q=%0h err=%0b expected q=%0h err=%0b",
                             d, i, qv[d], errv[d], mq[d], merr[d]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        model_reset();
        test_reset();
        test_johnson_up();
        test_johnson_down();
        test_illegal_load();
        test_ring();
        test_hold_async();
        test_back_to_back();
        test_dir_change();
        test_w8();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
